payout: RTL and testbench
=========================

# payout

Settlement block for the poker round: takes the wager chosen by the betting logic, deducts it from the money register at deal time, and credits the hand payout once the round result is known. Owns the authoritative money register and feeds it back to the betting logic as `money_r`. Credits are applied as a count-up, one step per cycle, so the display can animate the increase. Raises `done_o` when settlement is complete.

## Interface

- `INIT_MONEY`, 16'd1000: money register value after reset.
- `MONEY_MAX`, 16'd9999: saturation ceiling of the money register.
- `STEP`, 16'd10: maximum credit added per count-up cycle; nonzero.

- `clock`  in  1  clock; all state changes on the rising edge.
- `reset_c`  in  1  asynchronous, active-low reset.
- `deal_s`  in  1  single-cycle pulse; start of a round, lock the wager.
- `wager_i`  in  16  wager from the betting logic, unsigned.
- `result_v`  in  1  single-cycle pulse; `hand_rank` is valid.
- `hand_rank`  in  4  final hand code. 0 lose, 1 one pair, 2 two pair, 3 three of a kind, 4 straight, 5 flush, 6 full house, 7 four of a kind, 8 straight flush, 9 royal straight flush, 10–15 lose.
- `money_r`  out  16  current money register.
- `wager_l_o`  out  16  wager locked for the current round.
- `payout_o`  out  16  payout of the current round.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse when settlement finishes.
- `broke_o`  out  1  high when in IDLE and `money_r` == 0.

## Operation

- Reset values: state IDLE, `money_r`=INIT_MONEY, `wager_l_o`=0, `payout_o`=0, `busy_o`=0, `done_o`=0.
- Reset is honoured in any state, including mid count-up. It aborts the round and restores all reset values.
- **IDLE**
  - `deal_s` with `money_r` > 0: `wager_l_o` ← min(`wager_i`, `money_r`), `money_r` ← `money_r` − `wager_l_o`, `payout_o` ← 0, go to LOCKED.
  - A wager of 0 is locked as 0 and still goes to LOCKED.
  - `deal_s` with `money_r` == 0: ignored, stay in IDLE.
  - `result_v` is ignored in IDLE.
- **LOCKED**
  - Waits for `result_v`.
  - On `result_v`, the multiplier is chosen from `hand_rank`: 0→x0, 1→x1, 2→x2, 3→x3, 4→x4, 5→x5, 6→x10, 7→x20, 8→x25, 9→x250, 10–15→x0.
  - Product is `wager_l_o` × multiplier, computed at ≥25 bits. `payout_o` ← min(product, 65535).
  - Target is min(`money_r` + `payout_o`, MONEY_MAX), computed at 17 bits.
  - Next state is COUNT if target > `money_r`, otherwise DONE.
  - `deal_s` is ignored in LOCKED.
- **COUNT**
  - Each cycle, `money_r` ← `money_r` + min(STEP, target − `money_r`).
  - On the cycle `money_r` reaches target, go to DONE.
  - `deal_s` and `result_v` are ignored.
- **DONE**
  - One cycle with `done_o`=1, then go to IDLE.
  - `wager_l_o` and `payout_o` hold their values until the next deal.
- Simultaneous events:
  - `deal_s` and `result_v` in the same IDLE cycle: the deal is taken, the result is dropped.
  - In LOCKED, only `result_v` matters.
- `money_r` never exceeds MONEY_MAX and never underflows: the deduction is clamped to the available money.

## Timing

- `deal_s` sampled at edge N: new `money_r`, `wager_l_o` and LOCKED state are visible after edge N.
- `result_v` sampled at edge M: `payout_o` and the COUNT/DONE state are visible after edge M.
- Count-up length is ceil((target − money_before) / STEP) cycles. The first increment lands at edge M+1.
- `done_o` is high for exactly the cycle after the final increment, or the cycle after M for a zero credit.
- `busy_o` falls on the edge that ends DONE.
- Minimum round length from deal to IDLE: 3 cycles (zero payout).
- `broke_o` is registered from state and `money_r`. It is valid in the same cycle IDLE is entered.

## Test plan

- Reset: deassert `reset_c` → `money_r`=1000, `payout_o`=0, `wager_l_o`=0, `busy_o`=0, `done_o`=0, `broke_o`=0.
- Win count-up: deal with `wager_i`=100 → `money_r`=900. Then `result_v` with rank 2 → `payout_o`=200. `money_r` steps 910…1100 over 20 cycles, then `done_o` pulses once and the block returns to IDLE.
- Loss: deal with `wager_i`=100 from 1000, then rank 0 (repeat with rank 12) → `payout_o`=0, `money_r` stays 900, no COUNT cycles, `done_o` one cycle after `result_v`.
- Over-wager and broke:
  - `money_r`=1000, deal with `wager_i`=2000 → `wager_l_o`=1000, `money_r`=0.
  - Rank 0 → IDLE with `broke_o`=1.
  - Next `deal_s` is ignored: `busy_o` stays 0.
- Saturation: `money_r`=9000, `wager_i`=100 → 8900. Rank 9 → `payout_o`=25000, target 9999. Count-up takes 110 cycles, the last step is +9, and `money_r` ends at 9999.
- Stray inputs and reset mid-operation:
  - `result_v` in IDLE: no state change.
  - `deal_s` during COUNT: no state change.
  - Drop `reset_c` during COUNT → immediately `money_r`=1000, `payout_o`=0, `busy_o`=0.

Source files
------------

// File: rtl/payout_if.sv
// Settlement bus between the betting logic and the payout block.
// The betting logic drives the master side; the payout block is the slave.
interface payout_if;
   logic        deal_s;
   logic [15:0] wager_i;
   logic        result_v;
   logic [3:0]  hand_rank;
   logic [15:0] money_r;
   logic [15:0] wager_l_o;
   logic [15:0] payout_o;
   logic        busy_o;
   logic        done_o;
   logic        broke_o;

   modport master (
      output deal_s, wager_i, result_v, hand_rank,
      input  money_r, wager_l_o, payout_o, busy_o, done_o, broke_o
   );

   modport slave (
      input  deal_s, wager_i, result_v, hand_rank,
      output money_r, wager_l_o, payout_o, busy_o, done_o, broke_o
   );
endinterface

// File: rtl/payout.sv
// Round settlement: locks the wager at deal, then credits the hand payout
// as a per-cycle count-up toward a saturated target.
module payout #(
   parameter logic [15:0] INIT_MONEY = 16'd1000,
   parameter logic [15:0] MONEY_MAX  = 16'd9999,
   parameter logic [15:0] STEP       = 16'd10
) (
   input logic     clock,
   input logic     reset_c,
   payout_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StLocked, StCount, StDone} state_e;

   state_e      state_q, state_d;
   logic [15:0] money_q, money_d;
   logic [15:0] wager_q, wager_d;
   logic [15:0] payout_q, payout_d;
   logic [15:0] target_q, target_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        broke_q, broke_d;

   logic [7:0]  mult;
   logic [24:0] product;
   logic [15:0] pay_sat;
   logic [16:0] sum;
   logic [15:0] target_calc;
   logic [15:0] wager_lock;
   logic [15:0] credit;
   logic [15:0] step_amt;

   always_comb begin
      unique case (bus.hand_rank)
         4'd1:    mult = 8'd1;
         4'd2:    mult = 8'd2;
         4'd3:    mult = 8'd3;
         4'd4:    mult = 8'd4;
         4'd5:    mult = 8'd5;
         4'd6:    mult = 8'd10;
         4'd7:    mult = 8'd20;
         4'd8:    mult = 8'd25;
         4'd9:    mult = 8'd250;
         default: mult = 8'd0;
      endcase
   end

   // Wide enough that a maximal wager times the royal multiplier cannot wrap.
   always_comb begin
      product     = 25'(wager_q) * 25'(mult);
      pay_sat     = (product > 25'd65535) ? 16'hFFFF : product[15:0];
      sum         = {1'b0, money_q} + {1'b0, pay_sat};
      target_calc = (sum > {1'b0, MONEY_MAX}) ? MONEY_MAX : sum[15:0];
      wager_lock  = (bus.wager_i > money_q) ? money_q : bus.wager_i;
      credit      = target_q - money_q;
      step_amt    = (credit > STEP) ? STEP : credit;
   end

   always_comb begin
      state_d  = state_q;
      money_d  = money_q;
      wager_d  = wager_q;
      payout_d = payout_q;
      target_d = target_q;
      unique case (state_q)
         StIdle: begin
            if (bus.deal_s && money_q != 16'd0) begin
               wager_d  = wager_lock;
               money_d  = money_q - wager_lock;
               payout_d = 16'd0;
               state_d  = StLocked;
            end
         end
         StLocked: begin
            if (bus.result_v) begin
               payout_d = pay_sat;
               target_d = target_calc;
               state_d  = (target_calc > money_q) ? StCount : StDone;
            end
         end
         StCount: begin
            money_d = money_q + step_amt;
            if (money_d == target_q) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
      endcase
      // Status flags are registered from next-state so they line up with the state.
      busy_d  = (state_d != StIdle);
      done_d  = (state_d == StDone);
      broke_d = (state_d == StIdle) && (money_d == 16'd0);
   end

   always_ff @(posedge clock or negedge reset_c) begin
      if (!reset_c) begin
         state_q  <= StIdle;
         money_q  <= INIT_MONEY;
         wager_q  <= 16'd0;
         payout_q <= 16'd0;
         target_q <= 16'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         broke_q  <= (INIT_MONEY == 16'd0);
      end else begin
         state_q  <= state_d;
         money_q  <= money_d;
         wager_q  <= wager_d;
         payout_q <= payout_d;
         target_q <= target_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         broke_q  <= broke_d;
      end
   end

   assign bus.money_r   = money_q;
   assign bus.wager_l_o = wager_q;
   assign bus.payout_o  = payout_q;
   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.broke_o   = broke_q;

endmodule

// File: tb/tb_payout.sv
// Directed bench for payout: a money model queues the expected count-up
// trajectory when a result is driven, and each DUT cycle pops and compares.
module tb_payout;

   logic clock;
   logic reset_c;

   payout_if bus ();

   payout dut (
      .clock   (clock),
      .reset_c (reset_c),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   logic [15:0] exp_q[$];
   int unsigned m_money;
   int unsigned m_wager;
   int unsigned m_payout;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int unsigned mult_of(input logic [3:0] r);
      case (r)
         4'd1:    return 1;
         4'd2:    return 2;
         4'd3:    return 3;
         4'd4:    return 4;
         4'd5:    return 5;
         4'd6:    return 10;
         4'd7:    return 20;
         4'd8:    return 25;
         4'd9:    return 250;
         default: return 0;
      endcase
   endfunction

   task automatic deal(input string tag, input logic [15:0] w);
      int unsigned exp_busy;
      exp_busy = (m_money != 0) ? 1 : 0;
      if (m_money != 0) begin
         m_wager  = (int'(w) > m_money) ? m_money : int'(w);
         m_money  = m_money - m_wager;
         m_payout = 0;
      end
      bus.deal_s  = 1'b1;
      bus.wager_i = w;
      @(negedge clock);
      bus.deal_s  = 1'b0;
      check({tag, "_money"}, 32'(bus.money_r), m_money);
      check({tag, "_wager"}, 32'(bus.wager_l_o), m_wager);
      check({tag, "_payout"}, 32'(bus.payout_o), m_payout);
      check({tag, "_busy"}, 32'(bus.busy_o), exp_busy);
   endtask

   task automatic result(input string tag, input logic [3:0] rank);
      longint unsigned prod;
      int unsigned pay, tgt, m;
      prod = longint'(m_wager) * longint'(mult_of(rank));
      pay  = (prod > 65535) ? 65535 : int'(prod);
      tgt  = m_money + pay;
      if (tgt > 9999) tgt = 9999;
      m = m_money;
      while (m < tgt) begin
         m = (tgt - m > 10) ? m + 10 : tgt;
         exp_q.push_back(16'(m));
      end
      m_money  = tgt;
      m_payout = pay;
      bus.result_v  = 1'b1;
      bus.hand_rank = rank;
      @(negedge clock);
      bus.result_v  = 1'b0;
      check({tag, "_payout"}, 32'(bus.payout_o), m_payout);
      check({tag, "_busy"}, 32'(bus.busy_o), 1);
      check({tag, "_done0"}, 32'(bus.done_o), (exp_q.size() == 0) ? 1 : 0);
   endtask

   // One pop per cycle, so the loop is bounded by what the model queued.
   task automatic settle(input string tag, input int deal_at);
      logic [15:0] e;
      int k;
      k = 0;
      while (exp_q.size() != 0) begin
         if (k == deal_at) begin
            bus.deal_s  = 1'b1;
            bus.wager_i = 16'd50;
         end
         @(negedge clock);
         bus.deal_s = 1'b0;
         e = exp_q.pop_front();
         check({tag, "_step"}, 32'(bus.money_r), 32'(e));
         check({tag, "_done"}, 32'(bus.done_o), (exp_q.size() == 0) ? 1 : 0);
         k++;
      end
      @(negedge clock);
      check({tag, "_idle_done"}, 32'(bus.done_o), 0);
      check({tag, "_idle_busy"}, 32'(bus.busy_o), 0);
      check({tag, "_idle_money"}, 32'(bus.money_r), m_money);
   endtask

   initial begin
      reset_c       = 1'b0;
      bus.deal_s    = 1'b0;
      bus.wager_i   = 16'd0;
      bus.result_v  = 1'b0;
      bus.hand_rank = 4'd0;
      m_money  = 1000;
      m_wager  = 0;
      m_payout = 0;
      repeat (2) @(negedge clock);
      reset_c = 1'b1;
      @(negedge clock);
      check("rst_money", 32'(bus.money_r), 1000);
      check("rst_payout", 32'(bus.payout_o), 0);
      check("rst_wager", 32'(bus.wager_l_o), 0);
      check("rst_busy", 32'(bus.busy_o), 0);
      check("rst_done", 32'(bus.done_o), 0);
      check("rst_broke", 32'(bus.broke_o), 0);

      // Win count-up: 900 -> 1100 in 20 steps.
      deal("win_deal", 16'd100);
      result("win", 4'd2);
      check("win_len", 32'(exp_q.size()), 20);
      check("win_pay200", 32'(bus.payout_o), 200);
      settle("win", -1);
      check("win_final", 32'(bus.money_r), 1100);

      // Losses, including an out-of-table rank.
      deal("loss0_deal", 16'd100);
      result("loss0", 4'd0);
      settle("loss0", -1);
      deal("loss12_deal", 16'd100);
      result("loss12", 4'd12);
      settle("loss12", -1);
      check("loss_final", 32'(bus.money_r), 900);

      // Stray result in IDLE.
      bus.result_v  = 1'b1;
      bus.hand_rank = 4'd9;
      @(negedge clock);
      bus.result_v  = 1'b0;
      check("stray_res_busy", 32'(bus.busy_o), 0);
      check("stray_res_money", 32'(bus.money_r), 900);
      check("stray_res_payout", 32'(bus.payout_o), 0);

      // Deal and result together: deal wins, result dropped.
      bus.deal_s    = 1'b1;
      bus.wager_i   = 16'd100;
      bus.result_v  = 1'b1;
      bus.hand_rank = 4'd9;
      m_wager  = 100;
      m_money  = 800;
      m_payout = 0;
      @(negedge clock);
      bus.deal_s   = 1'b0;
      bus.result_v = 1'b0;
      check("simul_money", 32'(bus.money_r), 800);
      check("simul_payout", 32'(bus.payout_o), 0);
      check("simul_busy", 32'(bus.busy_o), 1);
      @(negedge clock);
      check("simul_hold_money", 32'(bus.money_r), 800);
      check("simul_hold_done", 32'(bus.done_o), 0);

      // Royal flush to the ceiling, with a stray deal mid count-up.
      result("jack", 4'd9);
      check("jack_pay", 32'(bus.payout_o), 25000);
      settle("jack", 5);
      check("jack_final", 32'(bus.money_r), 9999);

      // Saturation: 9000 -> 8900, then 110 steps to 9999, last one +9.
      deal("to9000_deal", 16'd999);
      result("to9000", 4'd0);
      settle("to9000", -1);
      deal("sat_deal", 16'd100);
      check("sat_8900", 32'(bus.money_r), 8900);
      result("sat", 4'd9);
      check("sat_len", 32'(exp_q.size()), 110);
      check("sat_pay", 32'(bus.payout_o), 25000);
      settle("sat", -1);
      check("sat_final", 32'(bus.money_r), 9999);

      // Reset in the middle of a count-up.
      deal("rst_deal", 16'd100);
      result("rstmid", 4'd2);
      repeat (3) @(negedge clock);
      reset_c = 1'b0;
      #1;
      check("rstmid_money", 32'(bus.money_r), 1000);
      check("rstmid_payout", 32'(bus.payout_o), 0);
      check("rstmid_busy", 32'(bus.busy_o), 0);
      check("rstmid_wager", 32'(bus.wager_l_o), 0);
      check("rstmid_done", 32'(bus.done_o), 0);
      exp_q.delete();
      m_money  = 1000;
      m_wager  = 0;
      m_payout = 0;
      @(negedge clock);
      reset_c = 1'b1;
      @(negedge clock);

      // Over-wager clamps to all money, then the player is broke.
      deal("over_deal", 16'd2000);
      check("over_wager", 32'(bus.wager_l_o), 1000);
      check("over_money", 32'(bus.money_r), 0);
      result("broke", 4'd0);
      settle("broke", -1);
      check("broke_flag", 32'(bus.broke_o), 1);
      deal("broke_deal", 16'd500);
      check("broke_still", 32'(bus.broke_o), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
